// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - front-panel LED driver: rate bar, heartbeat, cylon sweep, modes, PWM
// Rate is gated per window, turned into a thermometer bar by a serial divider, then muxed per display mode.
module led_sequencer #(
  parameter int N_LEDS        = 16,
  parameter int BAR_WIDTH     = 12,
  parameter int BAR_STEP      = 20000,
  parameter int WINDOW_CYCLES = 40000000,
  parameter int INC_WIDTH     = 8,
  parameter int BLINK_BITS    = 20,
  parameter int CYLON_BITS    = 21,
  parameter int PWM_BITS      = 4,
  parameter int IDLE_WINDOWS  = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          mmcm_locked,
  input  logic [1:0]                    mode_i,
  input  logic [PWM_BITS-1:0]           brightness_i,
  input  logic [INC_WIDTH-1:0]          increment_i,
  input  logic [N_LEDS-BAR_WIDTH-2:0]   status_i,
  output logic [31:0]                   rate_o,
  output logic [N_LEDS-1:0]             led_o
);

  localparam int WIN_W  = $clog2(WINDOW_CYCLES);
  localparam int N_W    = $clog2(BAR_WIDTH + 1);
  localparam int IDX_W  = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
  localparam int IDLE_W = (IDLE_WINDOWS > 0) ? $clog2(IDLE_WINDOWS + 1) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BAR_WIDTH - 1);

  typedef enum logic {IDLE, DIV} div_state_t;
  typedef enum logic [1:0] {LOCKWAIT, LOGIC, CYLON, OFF} disp_state_t;

  logic [WIN_W-1:0]      win_q, win_d;
  logic [31:0]           acc_q, acc_d;
  logic [31:0]           rate_q, rate_d;
  div_state_t            div_state_q, div_state_d;
  logic [31:0]           rem_q, rem_d;
  logic [N_W-1:0]        n_q, n_d;
  logic [BAR_WIDTH-1:0]  bar_q, bar_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic                  hb_q, hb_d;
  logic [CYLON_BITS-1:0] cyl_cnt_q, cyl_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  dir_up_q, dir_up_d;
  logic [PWM_BITS-1:0]   pwm_q, pwm_d;
  logic                  active_q, active_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  disp_state_t           disp_q, disp_d;
  logic [N_LEDS-1:0]     led_q, led_d;

  logic [32:0]           sum_wide;
  logic [31:0]           sum_sat;
  logic                  win_close;
  logic [BAR_WIDTH-1:0]  cyl_pos;
  logic                  pwm_on;
  disp_state_t           mode_sel;
  logic [N_LEDS-1:0]     src;

  assign sum_wide  = {1'b0, acc_q} + {{(33-INC_WIDTH){1'b0}}, increment_i};
  assign sum_sat   = sum_wide[32] ? '1 : sum_wide[31:0];
  assign win_close = (win_q == WIN_LAST);
  assign pwm_on    = (&brightness_i) | (pwm_q < brightness_i);

  always_comb begin
    win_d  = win_q + 1'b1;
    acc_d  = sum_sat;
    rate_d = rate_q;
    if (win_close) begin
      win_d  = '0;
      acc_d  = '0;
      rate_d = sum_sat;
    end
  end

  // Divider restarts on every window close, so a stale division never publishes a bar.
  always_comb begin
    div_state_d = div_state_q;
    rem_d       = rem_q;
    n_d         = n_q;
    bar_d       = bar_q;
    if (win_close) begin
      rem_d       = sum_sat;
      n_d         = '0;
      div_state_d = DIV;
    end else if (div_state_q == DIV) begin
      if (rem_q >= 32'(BAR_STEP) && n_q < N_W'(BAR_WIDTH)) begin
        rem_d = rem_q - 32'(BAR_STEP);
        n_d   = n_q + 1'b1;
      end else begin
        for (int i = 0; i < BAR_WIDTH; i++) bar_d[i] = (i < int'(n_q));
        div_state_d = IDLE;
      end
    end
  end

  always_comb begin
    blink_d   = blink_q + 1'b1;
    hb_d      = (blink_q == '0) ? ~hb_q : hb_q;
    cyl_cnt_d = cyl_cnt_q + 1'b1;
    pwm_d     = pwm_q + 1'b1;
    idx_d     = idx_q;
    dir_up_d  = dir_up_q;
    if (cyl_cnt_q == '1) begin
      if (dir_up_q) begin
        if (idx_q == IDX_LAST) begin
          idx_d    = idx_q - 1'b1;
          dir_up_d = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        if (idx_q == '0) begin
          idx_d    = idx_q + 1'b1;
          dir_up_d = 1'b1;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
    end
    cyl_pos = '0;
    for (int i = 0; i < BAR_WIDTH; i++) cyl_pos[i] = (i == int'(idx_q));
  end

  // A new increment wins over an idle clear; the two cannot coincide in practice anyway.
  always_comb begin
    active_d = active_q;
    idle_d   = idle_q;
    if (IDLE_WINDOWS > 0 && win_close) begin
      if (sum_sat == '0) begin
        if (idle_q == IDLE_W'(IDLE_WINDOWS - 1)) begin
          active_d = 1'b0;
          idle_d   = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end else begin
        idle_d = '0;
      end
    end
    if (increment_i != '0) active_d = 1'b1;
  end

  always_comb begin
    unique case (mode_i)
      2'd1:    mode_sel = LOGIC;
      2'd2:    mode_sel = CYLON;
      2'd3:    mode_sel = OFF;
      default: mode_sel = active_q ? CYLON : LOGIC;
    endcase
    disp_d = disp_q;
    if (!mmcm_locked) begin
      disp_d = LOCKWAIT;
    end else begin
      unique case (disp_q)
        LOCKWAIT: disp_d = mode_sel;
        default:  disp_d = mode_sel;
      endcase
    end

    // LEDs follow the next state so mode and lock changes show one cycle later.
    src = '0;
    src[N_LEDS-1:BAR_WIDTH+1] = status_i;
    src[BAR_WIDTH]            = hb_q;
    src[BAR_WIDTH-1:0]        = (disp_d == CYLON) ? cyl_pos : bar_q;
    unique case (disp_d)
      LOCKWAIT: led_d = {N_LEDS{hb_q}};
      OFF:      led_d = '0;
      default:  led_d = pwm_on ? src : '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      win_q       <= '0;
      acc_q       <= '0;
      rate_q      <= '0;
      div_state_q <= IDLE;
      rem_q       <= '0;
      n_q         <= '0;
      bar_q       <= '0;
      blink_q     <= '0;
      hb_q        <= 1'b0;
      cyl_cnt_q   <= '0;
      idx_q       <= '0;
      dir_up_q    <= 1'b1;
      pwm_q       <= '0;
      active_q    <= 1'b0;
      idle_q      <= '0;
      disp_q      <= LOCKWAIT;
      led_q       <= '0;
    end else begin
      win_q       <= win_d;
      acc_q       <= acc_d;
      rate_q      <= rate_d;
      div_state_q <= div_state_d;
      rem_q       <= rem_d;
      n_q         <= n_d;
      bar_q       <= bar_d;
      blink_q     <= blink_d;
      hb_q        <= hb_d;
      cyl_cnt_q   <= cyl_cnt_d;
      idx_q       <= idx_d;
      dir_up_q    <= dir_up_d;
      pwm_q       <= pwm_d;
      active_q    <= active_d;
      idle_q      <= idle_d;
      disp_q      <= disp_d;
      led_q       <= led_d;
    end
  end

  assign rate_o = rate_q;
  assign led_o  = led_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - bench for led_sequencer against a closed-form behavioural model
module tb_led_sequencer;

  localparam int N_LEDS        = 8;
  localparam int BAR_WIDTH     = 4;
  localparam int BAR_STEP      = 50;
  localparam int WINDOW_CYCLES = 100;
  localparam int INC_WIDTH     = 8;
  localparam int BLINK_BITS    = 3;
  localparam int CYLON_BITS    = 2;
  localparam int PWM_BITS      = 2;
  localparam int IDLE_WINDOWS  = 2;
  localparam longint MAXV      = 64'h0000_0000_FFFF_FFFF;

  logic                        clock = 1'b0;
  logic                        reset = 1'b1;
  logic                        mmcm_locked = 1'b0;
  logic [1:0]                  mode_i = 2'd0;
  logic [PWM_BITS-1:0]         brightness_i = '0;
  logic [INC_WIDTH-1:0]        increment_i = '0;
  logic [N_LEDS-BAR_WIDTH-2:0] status_i = '0;
  logic [31:0]                 rate_o;
  logic [N_LEDS-1:0]           led_o;

  led_sequencer #(
    .N_LEDS(N_LEDS), .BAR_WIDTH(BAR_WIDTH), .BAR_STEP(BAR_STEP),
    .WINDOW_CYCLES(WINDOW_CYCLES), .INC_WIDTH(INC_WIDTH), .BLINK_BITS(BLINK_BITS),
    .CYLON_BITS(CYLON_BITS), .PWM_BITS(PWM_BITS), .IDLE_WINDOWS(IDLE_WINDOWS)
  ) dut (
    .clock(clock), .reset(reset), .mmcm_locked(mmcm_locked), .mode_i(mode_i),
    .brightness_i(brightness_i), .increment_i(increment_i), .status_i(status_i),
    .rate_o(rate_o), .led_o(led_o)
  );

  always #5 clock = ~clock;

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "reset";

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: counters derived from edges since reset; bar published after its divide latency.
  longint           m_t, m_acc, m_rate;
  int               m_bar, m_pend_bar, m_pend_cnt, m_idle;
  bit               m_active;
  logic [N_LEDS-1:0] m_led;

  task automatic model_edge();
    int hb, p, s, ph, idx, st, k;
    bit on;
    longint sum;
    logic [N_LEDS-1:0] src;
    if (reset) begin
      m_t = 0; m_acc = 0; m_rate = 0; m_bar = 0; m_pend_cnt = 0; m_pend_bar = 0;
      m_active = 0; m_idle = 0; m_led = '0;
      return;
    end
    hb  = int'(((m_t + (1 << BLINK_BITS) - 1) / (1 << BLINK_BITS)) % 2);
    p   = int'(m_t % (1 << PWM_BITS));
    s   = int'(m_t / (1 << CYLON_BITS));
    ph  = s % (2 * (BAR_WIDTH - 1));
    idx = (ph < BAR_WIDTH) ? ph : 2 * (BAR_WIDTH - 1) - ph;
    if (!mmcm_locked) st = 0;
    else if (mode_i == 2'd0) st = m_active ? 2 : 1;
    else st = int'(mode_i);
    src = '0;
    src[N_LEDS-1:BAR_WIDTH+1] = status_i;
    src[BAR_WIDTH] = hb[0];
    src[BAR_WIDTH-1:0] = (st == 2) ? BAR_WIDTH'(1 << idx) : BAR_WIDTH'(m_bar);
    on = (brightness_i == '1) || (int'(brightness_i) > p);
    if (st == 0) m_led = {N_LEDS{hb[0]}};
    else if (st == 3) m_led = '0;
    else m_led = on ? src : '0;

    if (m_pend_cnt > 0) begin
      m_pend_cnt--;
      if (m_pend_cnt == 0) m_bar = m_pend_bar;
    end
    sum = m_acc + longint'(increment_i);
    if (sum > MAXV) sum = MAXV;
    if (m_t % WINDOW_CYCLES == WINDOW_CYCLES - 1) begin
      m_rate = sum;
      m_acc  = 0;
      k = (sum / BAR_STEP > BAR_WIDTH) ? BAR_WIDTH : int'(sum / BAR_STEP);
      m_pend_bar = (1 << k) - 1;
      m_pend_cnt = k + 1;
      if (sum == 0) begin
        m_idle++;
        if (m_idle == IDLE_WINDOWS) begin m_active = 0; m_idle = 0; end
      end else begin
        m_idle = 0;
      end
    end else begin
      m_acc = sum;
    end
    if (increment_i != 0) m_active = 1;
    m_t++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_eq({phase, ".led_o"}, 64'(led_o), 64'(m_led));
    check_eq({phase, ".rate_o"}, 64'(rate_o), 64'(m_rate));
  endtask

  int highs;
  int regime;

  initial begin
    repeat (3) tick();
    check_eq("reset.led0", 64'(led_o), 64'd0);
    reset = 1'b0;
    repeat (40) tick();
    check_eq("lockwait.rate0", 64'(rate_o), 64'd0);

    phase = "count1";
    mmcm_locked = 1'b1; mode_i = 2'd1; brightness_i = 2'd3; increment_i = 8'd1; status_i = 3'b101;
    repeat (250) tick();
    check_eq("count1.rate", 64'(rate_o), 64'd100);
    check_eq("count1.bar", 64'(led_o[3:0]), 64'h3);

    phase = "sat";
    increment_i = 8'd255;
    repeat (200) tick();
    check_eq("sat.rate", 64'(rate_o), 64'd25500);
    check_eq("sat.bar", 64'(led_o[3:0]), 64'hf);

    phase = "auto";
    increment_i = 8'd0;
    repeat (300) tick();
    mode_i = 2'd0;
    repeat (5) tick();
    check_eq("auto.idle_logic", 64'(led_o[3:0]), 64'h0);
    increment_i = 8'd1;
    tick();
    increment_i = 8'd0;
    repeat (12) tick();
    check_eq("auto.cylon_onehot", 64'($countones(led_o[3:0])), 64'd1);
    repeat (268) tick();
    check_eq("auto.revert", 64'(led_o[3:0]), 64'h0);

    phase = "pwm";
    mode_i = 2'd1; increment_i = 8'd255;
    repeat (150) tick();
    check_eq("pwm.bar_full", 64'(led_o[3:0]), 64'hf);
    brightness_i = 2'd1;
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      highs += int'(led_o[0]);
    end
    check_eq("pwm.duty_1of4", 64'(highs), 64'd4);
    brightness_i = 2'd0;
    repeat (8) tick();
    check_eq("pwm.dark", 64'(led_o), 64'd0);

    phase = "off";
    mode_i = 2'd3; brightness_i = 2'd3;
    repeat (3) tick();
    check_eq("off.leds", 64'(led_o), 64'd0);

    phase = "midreset";
    mode_i = 2'd1; increment_i = 8'd1;
    while (m_t % WINDOW_CYCLES != 50) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (99) tick();
    check_eq("midreset.rate_hold", 64'(rate_o), 64'd0);
    repeat (2) tick();
    check_eq("midreset.rate_post", 64'(rate_o), 64'd100);

    phase = "random";
    for (int w = 0; w < 30; w++) begin
      regime = int'($urandom_range(0, 2));
      for (int c = 0; c < WINDOW_CYCLES; c++) begin
        if ($urandom_range(0, 19) == 0) begin
          mode_i       = 2'($urandom_range(0, 3));
          brightness_i = PWM_BITS'($urandom_range(0, 3));
          status_i     = 3'($urandom_range(0, 7));
        end
        mmcm_locked = ($urandom_range(0, 29) != 0);
        case (regime)
          0:       increment_i = 8'd0;
          1:       increment_i = ($urandom_range(0, 9) == 0) ? 8'd1 : 8'd0;
          default: increment_i = 8'($urandom_range(0, 255));
        endcase
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
